pixel_tick_gen: RTL and testbench



---
 rtl/pixel_clk_pkg.sv | 10 +
 rtl/pixel_tick_gen.sv | 105 ++++++++++
 tb/tb_pixel_tick_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_clk_pkg.sv
// Shared constants for the fractional-N pixel timing generator.
package pixel_clk_pkg;

    localparam int unsigned ACC_W = 32;

    localparam logic [ACC_W-1:0] INC_25M175 = 32'd1081258017;
    localparam logic [ACC_W-1:0] INC_25M000 = 32'h4000_0000;
    localparam logic [ACC_W-1:0] INC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};

endpackage

// File: rtl/pixel_tick_gen.sv
// Phase-accumulator pixel strobe / pixel clock generator with a glitch-free,
// period-boundary increment update path.
module pixel_tick_gen
    import pixel_clk_pkg::*;
#(
    parameter int unsigned      ACC_W       = pixel_clk_pkg::ACC_W,
    parameter logic [ACC_W-1:0] DEFAULT_INC = INC_25M175
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             pix_ce,
    output logic             clk_pix,
    output logic [ACC_W-1:0] inc_active
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             pix_ce_q, pix_ce_d;
    logic             clk_pix_q, clk_pix_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic             boundary;
    logic             xfer;

    // Next-state: accumulate, apply pending increment at a boundary, accept requests.
    always_comb begin
        sum        = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d      = acc_q;
        carry      = 1'b0;
        inc_d      = inc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cfg_err_d  = 1'b0;

        if (sync) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = sum[ACC_W-1:0];
            carry = sum[ACC_W];
        end

        // Any point where swapping the increment cannot shorten a pixel period.
        boundary = carry || !enable || (inc_q == '0) || sync;
        xfer     = cfg_valid && cfg_ready_q;

        if (pend_vld_q && boundary) begin
            inc_d      = pend_q;
            pend_vld_d = 1'b0;
        end

        // xfer and apply are exclusive: xfer needs an empty pending slot.
        if (xfer) begin
            if (cfg_inc[ACC_W-1]) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_d     = cfg_inc;
                pend_vld_d = 1'b1;
            end
        end

        pix_ce_d    = carry;
        clk_pix_d   = acc_d[ACC_W-1];
        cfg_ready_d = !pend_vld_d;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            acc_q       <= '0;
            inc_q       <= DEFAULT_INC;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            pix_ce_q    <= 1'b0;
            clk_pix_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            pix_ce_q    <= pix_ce_d;
            clk_pix_q   <= clk_pix_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign cfg_err    = cfg_err_q;
    assign pix_ce     = pix_ce_q;
    assign clk_pix    = clk_pix_q;
    assign inc_active = inc_q;

endmodule

// File: tb/tb_pixel_tick_gen.sv
// Scoreboard bench for pixel_tick_gen against a phase/arithmetic reference model.
module tb_pixel_tick_gen;
    import pixel_clk_pkg::*;

    localparam longint TWO32 = 64'h1_0000_0000;
    localparam longint HALF  = 64'h8000_0000;
    localparam int     N_RUN = 20000;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sync = 1'b0;
    logic [31:0] cfg_inc = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, cfg_err, pix_ce, clk_pix;
    logic [31:0] inc_active;

    pixel_tick_gen dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .sync       (sync),
        .cfg_inc    (cfg_inc),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .pix_ce     (pix_ce),
        .clk_pix    (clk_pix),
        .inc_active (inc_active)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int unsigned idx;
        logic        pix;
        logic        clk;
        logic [31:0] inc;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model: phase in [0, 2^32), pending requests as a queue.
    longint      m_phase = 0;
    longint      m_inc = longint'(INC_25M175);
    longint      m_pend[$];
    logic        m_xfer;

    // Long-run measurement state, sampled by the monitor.
    logic        meas_en = 1'b0;
    int          meas_cnt = 0;
    logic        had_prev = 1'b0;
    int unsigned last_pulse = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: compare the DUT outputs against the expectation for this cycle.
    always @(negedge clk_in) begin
        if (exp_q.size() > 0 && exp_q[0].idx <= cyc) begin
            e = exp_q.pop_front();
            chk("slot", cyc, e.idx);
            chk("pix_ce", 32'(pix_ce), 32'(e.pix));
            chk("clk_pix", 32'(clk_pix), 32'(e.clk));
            chk("inc_active", inc_active, e.inc);
            chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
            chk("cfg_err", 32'(cfg_err), 32'(e.err));
        end
        if (meas_en && pix_ce === 1'b1) begin
            meas_cnt++;
            if (had_prev) begin
                n_cmp++;
                if (cyc - last_pulse < 3 || cyc - last_pulse > 4) begin
                    n_bad++;
                    $display("FAIL interval: got %0d want 3..4", cyc - last_pulse);
                end
            end
            had_prev   = 1'b1;
            last_pulse = cyc;
        end
    end

    // Drive one cycle of inputs and push the model's expectation for that edge.
    task automatic step(input logic r, input logic en, input logic s,
                        input logic v, input logic [31:0] ci);
        exp_t   x;
        logic   wrapped;
        logic   rdy;
        logic   err;
        longint t;
        @(posedge clk_in);
        #1;
        reset = r; enable = en; sync = s; cfg_valid = v; cfg_inc = ci;
        wrapped = 1'b0;
        err     = 1'b0;
        m_xfer  = 1'b0;
        if (r) begin
            m_phase = 0;
            m_inc   = longint'(INC_25M175);
            m_pend.delete();
        end else begin
            rdy = (m_pend.size() == 0);
            if (s) begin
                t = 0;
            end else if (en) begin
                t       = m_phase + m_inc;
                wrapped = (t >= TWO32);
                t       = t % TWO32;
            end else begin
                t = m_phase;
            end
            if (m_pend.size() > 0 && (wrapped || !en || m_inc == 0 || s))
                m_inc = m_pend.pop_front();
            if (v && rdy) begin
                m_xfer = 1'b1;
                if (longint'(ci) < HALF) m_pend.push_back(longint'(ci));
                else err = 1'b1;
            end
            m_phase = t;
        end
        x.idx = cyc + 1;
        x.pix = wrapped;
        x.clk = (m_phase >= HALF);
        x.inc = 32'(m_inc);
        x.rdy = (m_pend.size() == 0);
        x.err = err;
        exp_q.push_back(x);
    endtask

    initial begin
        logic        hold;
        logic [31:0] hv;
        longint      want_lo;

        // Reset, then load 1/4 rate while disabled and run.
        repeat (3) step(1, 0, 0, 0, '0);
        step(0, 0, 0, 1, INC_25M000);
        step(0, 0, 0, 0, '0);
        repeat (20) step(0, 1, 0, 0, '0);

        // Halve the rate while running; switch lands on a carry.
        step(0, 1, 0, 1, 32'h2000_0000);
        repeat (20) step(0, 1, 0, 0, '0);

        // Out-of-range request is rejected.
        step(0, 1, 0, 1, 32'h8000_0000);
        repeat (6) step(0, 1, 0, 0, '0);

        // Sync mid-period with an update pending.
        repeat (3) step(0, 1, 0, 0, '0);
        step(0, 1, 0, 1, INC_25M000);
        step(0, 1, 1, 0, '0);
        repeat (12) step(0, 1, 0, 0, '0);

        // Sync together with a transfer: captured now, applied later.
        step(0, 1, 1, 1, 32'h1000_0000);
        repeat (6) step(0, 1, 0, 0, '0);

        // Reset with a pending update while enabled.
        repeat (2) step(0, 1, 0, 0, '0);
        step(0, 1, 0, 1, 32'h0800_0000);
        step(1, 1, 0, 0, '0);
        step(0, 0, 0, 0, '0);

        // Long run at the default increment from phase 0.
        meas_cnt = 0;
        had_prev = 1'b0;
        meas_en  = 1'b1;
        for (int i = 0; i < N_RUN; i++) step(0, 1, 0, 0, '0);
        repeat (2) step(0, 0, 0, 0, '0);
        meas_en = 1'b0;
        want_lo = (longint'(N_RUN) * longint'(INC_25M175)) >> 32;
        n_cmp++;
        if (longint'(meas_cnt) < want_lo || longint'(meas_cnt) > want_lo + 1) begin
            n_bad++;
            $display("FAIL long_run_count: got %0d want %0d..%0d", meas_cnt, want_lo, want_lo + 1);
        end

        // Randomized traffic; requester holds its value until accepted.
        hold = 1'b0;
        hv   = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold && $urandom_range(0, 5) == 0) begin
                hold = 1'b1;
                case ($urandom_range(0, 5))
                    0: hv = INC_25M000;
                    1: hv = 32'h2000_0000;
                    2: hv = INC_25M175;
                    3: hv = '0;
                    4: hv = $urandom & INC_MAX;
                    default: hv = $urandom | 32'h8000_0000;
                endcase
            end
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 39) == 0), hold, hv);
            if (m_xfer) hold = 1'b0;
        end
        step(0, 0, 0, 0, '0);

        repeat (2) @(negedge clk_in);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
